plot_sweeper: RTL and testbench
===============================

PLOT_SWEEPER -- requirements
Module: plot_sweeper

Interface
REQ-001 SHALL have parameter INTEGER_PART_WIDTH, default 8: integer bits of the fixed-point number.
REQ-002 SHALL have parameter FRACTIONAL_PART_WIDTH, default 8: fraction bits; NUMBER_WIDTH = sum of the two.
REQ-003 SHALL have parameter HOR_ACTIVE_PIXELS, default 640: columns swept per frame.
REQ-004 SHALL have parameter VER_ACTIVE_PIXELS, default 480: valid row range.
REQ-005 SHALL use one clock and an asynchronous, active-low reset, with ports as below.
REQ-006 SHALL have port clk  in  1  clock.
REQ-007 SHALL have port rst_n  in  1  reset.
REQ-008 SHALL have port redraw  in  1  one-cycle request to recompute all columns.
REQ-009 SHALL have port busy  out  1  high while a frame sweep is in progress.
REQ-010 SHALL have port frame_done  out  1  one-cycle pulse after the last column is written.
REQ-011 SHALL have port sm_start  out  1  start pulse to the expression evaluator.
REQ-012 SHALL have port sm_x  out  NUMBER_WIDTH  column index, zero-extended.
REQ-013 SHALL have port sm_ready  in  1  evaluator done/idle flag.
REQ-014 SHALL have port sm_y  in  NUMBER_WIDTH  evaluator row result, two's complement.
REQ-015 SHALL have port rd_x  in  clog2(HOR_ACTIVE_PIXELS)  display read column.
REQ-016 SHALL have port rd_y  out  clog2(VER_ACTIVE_PIXELS)  stored row for rd_x.
REQ-017 SHALL have port rd_valid  out  1  stored row is in range and a frame has completed.

Function
REQ-018 SHALL run FSM IDLE -> ISSUE -> GAP -> WAIT -> WRITE, then ISSUE (next column) or DONE -> IDLE.
REQ-019 SHALL leave IDLE on redraw or a pending request, setting column to 0 and busy to 1.
REQ-020 SHALL, in ISSUE, drive sm_start=1 for exactly one cycle, with sm_x = column held stable until WRITE.
REQ-021 SHALL, in GAP, ignore sm_ready for one cycle, because the stale ready clears one cycle after start.
REQ-022 SHALL stay in WAIT until sm_ready=1, then capture sm_y; there is no timeout.
REQ-023 SHALL, in WRITE, store {in_range, sm_y[row bits]} at the column, where in_range = (sm_y signed >= 0 and < VER_ACTIVE_PIXELS).
REQ-024 SHALL go from WRITE to DONE at column HOR_ACTIVE_PIXELS-1; otherwise it increments the column and goes to ISSUE, with no wrap past the last column.
REQ-025 SHALL, in DONE, pulse frame_done for one cycle, clear busy, and set the frame_seen flag.
REQ-026 SHALL treat redraw while busy as a single pending bit; multiple requests merge, and the next frame starts the cycle after DONE.
REQ-027 SHALL treat redraw coincident with DONE as pending, not lost.
REQ-028 SHALL give rd_y/rd_valid a registered read with 1-cycle latency; rd_valid = stored in_range AND frame_seen.
REQ-029 SHALL resolve simultaneous read and write of the same column as read-old-data.

Reset
REQ-030 SHALL, on rst_n low, asynchronously force IDLE, busy=0, frame_done=0, sm_start=0, sm_x=0, pending=0, frame_seen=0, rd_valid=0, rd_y=0.
REQ-031 SHALL not reset column memory contents; frame_seen gates their visibility.
REQ-032 SHALL, on reset mid-sweep, abandon the sweep with no frame_done; the evaluator is not reset and its next ready is ignored until a new ISSUE.

Configuration
REQ-033 SHALL, with PLOT_SWEEPER_DOUBLE_BUFFER_EN defined, keep two column banks: write to the back bank, read the front bank, swap in DONE, so display never sees a partial frame.
REQ-034 SHALL, without the macro, keep a single bank, write it in place, and let reads see new columns as written.

Structure
REQ-035 SHALL place NUMBER_WIDTH, width helpers, and the FSM state enum in shared package plot_pkg.
REQ-036 SHALL implement storage as sub-module column_ram (1 write port, 1 registered read port, width clog2(VER)+1), instantiated once or twice.

Verification
REQ-037 SHALL verify reset with rst_n low: busy=0, sm_start=0, frame_done=0, rd_valid=0 with rd_x=5.
REQ-038 SHALL verify redraw with an evaluator model y=x/2 at 5-cycle latency: 640 sm_start pulses, sm_x 0..639 in order, one frame_done; then rd_x=100 gives rd_y=50, rd_valid=1.
REQ-039 SHALL verify range: model y=0xFFFD at x=10 and y=480 at x=11 gives rd_valid=0; y=479 at x=12 gives rd_valid=1, rd_y=479.
REQ-040 SHALL verify pending: three redraw pulses during column 300 give exactly one extra frame, starting the cycle after the first frame_done.
REQ-041 SHALL verify reset mid-sweep: rst_n low while in WAIT at column 200 gives no frame_done and rd_valid=0 until the next full frame completes.
REQ-042 SHALL verify double buffering: with PLOT_SWEEPER_DOUBLE_BUFFER_EN, frame 1 at y=x/2 and frame 2 at y=7, rd_x=100 returns 50 until the second frame_done, then 7.

Source files
------------

// File: rtl/plot_pkg.sv
// plot_pkg: shared widths, width helpers and sweep FSM states for plot_sweeper.
package plot_pkg;
  localparam int NUMBER_WIDTH = 16;
  function automatic int number_width(input int i, input int f);
    return i + f;
  endfunction
  function automatic int addr_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_GAP, S_WAIT, S_WRITE, S_DONE} state_t;
endpackage

// File: rtl/column_ram.sv
// column_ram: one write port, one registered read port; contents are never reset.
module column_ram #(
  parameter int DEPTH = 640,
  parameter int AW = 10,
  parameter int DW = 10
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic [AW-1:0] ra,
  output logic [DW-1:0] q
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else q <= mem[ra];
endmodule

// File: rtl/plot_sweeper.sv
// plot_sweeper: sweeps every column through the evaluator and stores the resulting row.
// Define PLOT_SWEEPER_DOUBLE_BUFFER_EN for front/back column banks swapped at frame end.
module plot_sweeper import plot_pkg::*; #(
  parameter int INTEGER_PART_WIDTH = 8,
  parameter int FRACTIONAL_PART_WIDTH = 8,
  parameter int HOR_ACTIVE_PIXELS = 640,
  parameter int VER_ACTIVE_PIXELS = 480
)(
  input  logic clk,
  input  logic rst_n,
  input  logic redraw,
  output logic busy,
  output logic frame_done,
  output logic sm_start,
  output logic [number_width(INTEGER_PART_WIDTH, FRACTIONAL_PART_WIDTH)-1:0] sm_x,
  input  logic sm_ready,
  input  logic [number_width(INTEGER_PART_WIDTH, FRACTIONAL_PART_WIDTH)-1:0] sm_y,
  input  logic [addr_width(HOR_ACTIVE_PIXELS)-1:0] rd_x,
  output logic [addr_width(VER_ACTIVE_PIXELS)-1:0] rd_y,
  output logic rd_valid
);
  localparam int NW = number_width(INTEGER_PART_WIDTH, FRACTIONAL_PART_WIDTH);
  localparam int AW = addr_width(HOR_ACTIVE_PIXELS);
  localparam int RW = addr_width(VER_ACTIVE_PIXELS);
  localparam int DW = RW + 1;
  state_t state, nxt;
  logic [AW-1:0] col;
  logic [NW-1:0] y_cap;
  logic pending, frame_seen, last, go, in_range, we;
  logic [DW-1:0] wd, q;
  assign last = col == AW'(HOR_ACTIVE_PIXELS - 1);
  assign go = redraw || pending;
  assign in_range = !y_cap[NW-1] && int'(y_cap) < VER_ACTIVE_PIXELS;
  assign we = state == S_WRITE;
  assign wd = {in_range, y_cap[RW-1:0]};
  assign sm_x = NW'(col);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      col <= '0;
      y_cap <= '0;
      pending <= 1'b0;
      frame_seen <= 1'b0;
    end else begin
      state <= nxt;
      if (state == S_IDLE && go) col <= '0;
      else if (state == S_WRITE && !last) col <= col + 1'b1;
      if (state == S_WAIT && sm_ready) y_cap <= sm_y;
      // requests during a sweep (including DONE) merge into one pending frame
      pending <= state == S_IDLE ? 1'b0 : pending || redraw;
      if (state == S_DONE) frame_seen <= 1'b1;
    end
  always_comb begin
    nxt = state;
    sm_start = 1'b0;
    frame_done = 1'b0;
    busy = 1'b0;
    case (state)
      S_IDLE:  nxt = go ? S_ISSUE : S_IDLE;
      S_ISSUE: begin nxt = S_GAP; sm_start = 1'b1; busy = 1'b1; end
      S_GAP:   begin nxt = S_WAIT; busy = 1'b1; end
      S_WAIT:  begin nxt = sm_ready ? S_WRITE : S_WAIT; busy = 1'b1; end
      S_WRITE: begin nxt = last ? S_DONE : S_ISSUE; busy = 1'b1; end
      S_DONE:  begin nxt = S_IDLE; frame_done = 1'b1; end
      default: nxt = S_IDLE;
    endcase
  end
`ifdef PLOT_SWEEPER_DOUBLE_BUFFER_EN
  logic front, rd_front;
  logic [DW-1:0] q0, q1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      front <= 1'b0;
      rd_front <= 1'b0;
    end else begin
      if (state == S_DONE) front <= ~front;
      rd_front <= front;
    end
  column_ram #(.DEPTH(HOR_ACTIVE_PIXELS), .AW(AW), .DW(DW)) u_bank0 (
    .clk(clk), .rst_n(rst_n), .we(we && front), .wa(col), .wd(wd), .ra(rd_x), .q(q0));
  column_ram #(.DEPTH(HOR_ACTIVE_PIXELS), .AW(AW), .DW(DW)) u_bank1 (
    .clk(clk), .rst_n(rst_n), .we(we && !front), .wa(col), .wd(wd), .ra(rd_x), .q(q1));
  assign q = rd_front ? q1 : q0;
`else
  column_ram #(.DEPTH(HOR_ACTIVE_PIXELS), .AW(AW), .DW(DW)) u_bank (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(col), .wd(wd), .ra(rd_x), .q(q));
`endif
  assign rd_y = q[RW-1:0];
  assign rd_valid = q[RW] && frame_seen;
endmodule

// File: tb/tb_plot_sweeper.sv
// tb_plot_sweeper: randomized checks of plot_sweeper against a frame-level reference model.
module tb_plot_sweeper;
  logic clk = 0, rst_n = 0, redraw = 0, sm_ready = 1;
  logic [15:0] sm_y = 0;
  logic [9:0] rd_x = 0;
  logic busy, frame_done, sm_start, rd_valid;
  logic [15:0] sm_x;
  logic [8:0] rd_y;
  int checks = 0, errors = 0, fd = 0, lat = 5, cnt = 0;
  logic [15:0] xs[$];
  logic [15:0] ytab[640];
  logic [15:0] mem_m[640];
  bit seen_m = 0, clr = 0;
  logic [9:0] xl = 0;

  plot_sweeper dut (.clk(clk), .rst_n(rst_n), .redraw(redraw), .busy(busy), .frame_done(frame_done),
    .sm_start(sm_start), .sm_x(sm_x), .sm_ready(sm_ready), .sm_y(sm_y), .rd_x(rd_x), .rd_y(rd_y),
    .rd_valid(rd_valid));

  always #5 clk = ~clk;

  // evaluator: ready stays stale one cycle after start, then reports ytab[x] after lat cycles
  always @(posedge clk) begin
    if (sm_start) begin
      cnt <= lat;
      xl <= sm_x[9:0];
      clr <= 1;
    end else begin
      clr <= 0;
      if (clr) sm_ready <= 0;
      if (cnt == 1) begin sm_ready <= 1; sm_y <= ytab[xl]; end
      if (cnt != 0) cnt <= cnt - 1;
    end
  end

  always @(negedge clk) begin
    if (sm_start) xs.push_back(sm_x);
    if (frame_done) fd++;
  end

  function automatic bit exp_ok(input logic [15:0] v);
    return seen_m && !v[15] && v < 16'd480;
  endfunction

  task automatic pulse_redraw();
    @(negedge clk) redraw = 1;
    @(negedge clk) redraw = 0;
  endtask

  task automatic wait_frame(output bit ok);
    ok = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (frame_done) begin ok = 1; break; end
    end
  endtask

  task automatic wait_start(input int x, output bit ok);
    ok = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (sm_start && sm_x == 16'(x)) begin ok = 1; break; end
    end
  endtask

  task automatic commit();
    for (int i = 0; i < 640; i++) mem_m[i] = ytab[i];
    seen_m = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    rd_x = 5;
    #12;
    checks += 5;
    if (busy !== 0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (sm_start !== 0) begin errors++; $display("FAIL reset_sm_start got=%b exp=0", sm_start); end
    if (frame_done !== 0) begin errors++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
    if (rd_valid !== 0) begin errors++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    if (rd_y !== 0) begin errors++; $display("FAIL reset_rd_y got=%0d exp=0", rd_y); end
    @(negedge clk) rst_n = 1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_redraw();
    bit ok;
    int n0, fd0, bad;
    lat = 5;
    for (int i = 0; i < 640; i++) ytab[i] = 16'(i / 2);
    n0 = xs.size();
    fd0 = fd;
    pulse_redraw();
    wait_frame(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL redraw_timeout got=no_frame_done exp=frame_done"); end
    commit();
    repeat (5) @(negedge clk);
    checks += 3;
    if (xs.size() - n0 != 640) begin errors++; $display("FAIL redraw_starts got=%0d exp=640", xs.size() - n0); end
    if (fd - fd0 != 1) begin errors++; $display("FAIL redraw_frames got=%0d exp=1", fd - fd0); end
    if (busy !== 0) begin errors++; $display("FAIL redraw_busy_after got=%b exp=0", busy); end
    bad = 0;
    if (xs.size() - n0 >= 640) for (int i = 0; i < 640; i++) if (xs[n0 + i] !== 16'(i)) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL redraw_x_order got=%0d_out_of_order exp=0", bad); end
    @(negedge clk) rd_x = 100;
    @(negedge clk);
    checks++;
    if (rd_y !== 9'd50 || rd_valid !== 1) begin errors++; $display("FAIL redraw_rd100 got=%0d/%b exp=50/1", rd_y, rd_valid); end
  endtask

  task automatic test_range();
    bit ok;
    int c;
    lat = $urandom_range(2, 6);
    for (int i = 0; i < 640; i++) ytab[i] = 16'($urandom_range(0, 1100)) - 16'd300;
    ytab[10] = 16'hFFFD;
    ytab[11] = 16'd480;
    ytab[12] = 16'd479;
    pulse_redraw();
    wait_frame(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL range_timeout got=no_frame_done exp=frame_done"); end
    commit();
    for (int k = 0; k < 23; k++) begin
      c = k < 3 ? 10 + k : $urandom_range(0, 639);
      @(negedge clk) rd_x = 10'(c);
      @(negedge clk);
      checks++;
      if (rd_valid !== exp_ok(mem_m[c]) || rd_y !== mem_m[c][8:0]) begin
        errors++;
        $display("FAIL range_col%0d got=%0d/%b exp=%0d/%b", c, rd_y, rd_valid, mem_m[c][8:0], exp_ok(mem_m[c]));
      end
    end
  endtask

  task automatic test_pending();
    bit ok;
    int n0, fd0, k;
    lat = $urandom_range(2, 5);
    for (int i = 0; i < 640; i++) ytab[i] = 16'(i % 500);
    n0 = xs.size();
    fd0 = fd;
    pulse_redraw();
    wait_start(300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL pending_col300_timeout got=none exp=start"); end
    repeat (3) begin
      @(negedge clk) redraw = 1;
      @(negedge clk) redraw = 0;
    end
    wait_frame(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL pending_first_timeout got=no_frame_done exp=frame_done"); end
    k = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (sm_start) begin k = i; break; end
    end
    checks++;
    if (k < 1 || k > 2) begin errors++; $display("FAIL pending_restart_delay got=%0d exp=1..2", k); end
    wait_frame(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL pending_second_timeout got=no_frame_done exp=frame_done"); end
    commit();
    repeat (50) @(negedge clk);
    checks += 3;
    if (fd - fd0 != 2) begin errors++; $display("FAIL pending_frames got=%0d exp=2", fd - fd0); end
    if (xs.size() - n0 != 1280) begin errors++; $display("FAIL pending_starts got=%0d exp=1280", xs.size() - n0); end
    if (busy !== 0) begin errors++; $display("FAIL pending_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int fd0, c;
    lat = 5;
    for (int i = 0; i < 640; i++) ytab[i] = 16'((i * 3) % 500);
    pulse_redraw();
    wait_start(200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL resetmid_col200_timeout got=none exp=start"); end
    repeat (2) @(negedge clk);
    rst_n = 0;
    seen_m = 0;
    #1;
    checks++;
    if (busy !== 0) begin errors++; $display("FAIL resetmid_busy got=%b exp=0", busy); end
    @(negedge clk) rst_n = 1;
    fd0 = fd;
    rd_x = 100;
    repeat (30) @(negedge clk);
    checks += 3;
    if (fd != fd0) begin errors++; $display("FAIL resetmid_frame_done got=%0d exp=0", fd - fd0); end
    if (busy !== 0) begin errors++; $display("FAIL resetmid_idle got=%b exp=0", busy); end
    if (rd_valid !== 0) begin errors++; $display("FAIL resetmid_rd_valid got=%b exp=0", rd_valid); end
    pulse_redraw();
    wait_start(5, ok);
    @(negedge clk) rd_x = 0;
    @(negedge clk);
    checks++;
    if (rd_valid !== 0) begin errors++; $display("FAIL resetmid_partial_valid got=%b exp=0", rd_valid); end
    wait_frame(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL resetmid_timeout got=no_frame_done exp=frame_done"); end
    commit();
    for (int k = 0; k < 8; k++) begin
      c = k == 0 ? 100 : $urandom_range(0, 639);
      @(negedge clk) rd_x = 10'(c);
      @(negedge clk);
      checks++;
      if (rd_valid !== exp_ok(mem_m[c]) || rd_y !== mem_m[c][8:0]) begin
        errors++;
        $display("FAIL resetmid_col%0d got=%0d/%b exp=%0d/%b", c, rd_y, rd_valid, mem_m[c][8:0], exp_ok(mem_m[c]));
      end
    end
  endtask

  task automatic test_buffer();
    bit ok;
    lat = 3;
    for (int i = 0; i < 640; i++) ytab[i] = 16'(i / 2);
    pulse_redraw();
    wait_frame(ok);
    commit();
    for (int i = 0; i < 640; i++) ytab[i] = 16'd7;
    @(negedge clk) rd_x = 100;
    pulse_redraw();
    wait_start(500, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL buffer_col500_timeout got=none exp=start"); end
    @(negedge clk);
    checks++;
`ifdef PLOT_SWEEPER_DOUBLE_BUFFER_EN
    if (rd_y !== 9'd50 || rd_valid !== 1) begin errors++; $display("FAIL buffer_mid_frame got=%0d/%b exp=50/1", rd_y, rd_valid); end
`else
    if (rd_y !== 9'd7 || rd_valid !== 1) begin errors++; $display("FAIL buffer_mid_frame got=%0d/%b exp=7/1", rd_y, rd_valid); end
`endif
    wait_frame(ok);
    checks++;
`ifdef PLOT_SWEEPER_DOUBLE_BUFFER_EN
    if (!ok || rd_y !== 9'd50) begin errors++; $display("FAIL buffer_at_done got=%0d exp=50", rd_y); end
`else
    if (!ok || rd_y !== 9'd7) begin errors++; $display("FAIL buffer_at_done got=%0d exp=7", rd_y); end
`endif
    commit();
    repeat (3) @(negedge clk);
    checks++;
    if (rd_y !== mem_m[100][8:0] || rd_valid !== exp_ok(mem_m[100])) begin
      errors++;
      $display("FAIL buffer_after_done got=%0d/%b exp=%0d/%b", rd_y, rd_valid, mem_m[100][8:0], exp_ok(mem_m[100]));
    end
  endtask

  initial begin
    test_reset();
    test_redraw();
    test_range();
    test_pending();
    test_reset_mid();
    test_buffer();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
